match_grid_ctrl: RTL and testbench

- Cursor/selection controller for the colour-matching game, generalised to a COLS x ROWS grid (default 4x2 = 8 squares).
- Takes one-hot direction switches and the select button. Moves a cursor that skips matched squares. Reveals two squares per turn and compares their colours.
- Marks a pair matched, or hides both squares again after a hold time.
- Drives per-square state codes to the VGA renderer and reports match progress.

---
 rtl/match_grid_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_match_grid_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/match_grid_ctrl.sv
// -----------------------------------------------------------------------------
// match_grid_ctrl
// Cursor and selection controller for a COLS x ROWS colour-matching game.
// The player moves a cursor with one-hot direction switches. The cursor skips
// squares that are already matched. The player reveals two squares per turn.
// A matching pair stays matched. A non-matching pair is shown for SHOW_CYCLES
// clocks and then hidden again.
//
// Ports:
//   clk25MHz       in   system clock
//   rst            in   asynchronous active-low reset
//   switches       in   direction (1000 up, 0100 down, 0010 left, 0001 right)
//   select_button  in   active-high select
//   colors         in   colour of square i on [i*COLOR_W +: COLOR_W]
//   sq_state       out  per-square code on [2i+1:2i]
//                       (00 hidden, 01 cursor, 10 revealed, 11 matched)
//   cursor         out  current cursor index
//   match_count    out  number of matched pairs
//   mismatch       out  one-cycle pulse when a compare fails
//   game_done      out  high once every pair is matched
// -----------------------------------------------------------------------------
module match_grid_ctrl #(
    parameter int COLS        = 4,
    parameter int ROWS        = 2,
    parameter int IDX_W       = 3,
    parameter int COLOR_W     = 3,
    parameter int SHOW_CYCLES = 25000000,
    parameter int CNT_W       = 25
) (
    input  logic                          clk25MHz,
    input  logic                          rst,
    input  logic [3:0]                    switches,
    input  logic                          select_button,
    input  logic [COLS*ROWS*COLOR_W-1:0]  colors,
    output logic [2*COLS*ROWS-1:0]        sq_state,
    output logic [IDX_W-1:0]              cursor,
    output logic [IDX_W-1:0]              match_count,
    output logic                          mismatch,
    output logic                          game_done
);

    localparam int N       = COLS * ROWS;
    localparam int STEP_DN = COLS % N;
    localparam int STEP_UP = (N - STEP_DN) % N;
    localparam logic [IDX_W:0]   N_W       = (IDX_W+1)'(N);
    localparam logic [IDX_W-1:0] HALF_W    = IDX_W'(N / 2);
    localparam logic [CNT_W-1:0] SHOW_LOAD = CNT_W'(SHOW_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_ONE, S_CHECK, S_SHOW, S_DONE} state_t;

    state_t             r_state, w_state_nxt;
    logic [3:0]         r_sw_meta, r_sw_sync, r_sw_prev;
    logic               r_sel_meta, r_sel_sync, r_sel_prev;
    logic [IDX_W-1:0]   r_cursor, r_first, r_second, r_match_cnt;
    logic [N-1:0]       r_revealed, r_matched;
    logic [CNT_W-1:0]   r_timer;
    logic               r_mismatch, r_game_done;

    logic               w_move_evt, w_sel_evt, w_move_ok, w_cur_hidden, w_colors_eq;
    logic               w_take_first, w_take_second, w_do_match, w_do_mismatch, w_do_hide;
    logic [IDX_W:0]     w_step;
    logic [IDX_W-1:0]   w_target, w_cnt_inc;

    // Two-flop synchronisers plus one history flop for edge detection.
    always_ff @(posedge clk25MHz or negedge rst) begin
        if (!rst) begin
            r_sw_meta  <= 4'b0000;
            r_sw_sync  <= 4'b0000;
            r_sw_prev  <= 4'b0000;
            r_sel_meta <= 1'b0;
            r_sel_sync <= 1'b0;
            r_sel_prev <= 1'b0;
        end else begin
            r_sw_meta  <= switches;
            r_sw_sync  <= r_sw_meta;
            r_sw_prev  <= r_sw_sync;
            r_sel_meta <= select_button;
            r_sel_sync <= r_sel_meta;
            r_sel_prev <= r_sel_sync;
        end
    end

    // A move fires only when the switches leave 0000 for a one-hot value.
    assign w_move_evt = (r_sw_prev == 4'b0000) &&
                        ((r_sw_sync == 4'b1000) || (r_sw_sync == 4'b0100) ||
                         (r_sw_sync == 4'b0010) || (r_sw_sync == 4'b0001));
    assign w_sel_evt  = r_sel_sync && !r_sel_prev;

    // Step size modulo N for the requested direction.
    always_comb begin
        w_step = '0;
        case (r_sw_sync)
            4'b0001: w_step = (IDX_W+1)'(1);
            4'b0010: w_step = (IDX_W+1)'(N - 1);
            4'b0100: w_step = (IDX_W+1)'(STEP_DN);
            4'b1000: w_step = (IDX_W+1)'(STEP_UP);
            default: w_step = '0;
        endcase
    end

    // Walk up to N-1 steps; the first unmatched square wins, otherwise stay put.
    always_comb begin : p_target
        logic [IDX_W:0] w_probe;
        logic           w_found;
        w_target = r_cursor;
        w_found  = 1'b0;
        w_probe  = {1'b0, r_cursor};
        for (int k = 0; k < N - 1; k++) begin
            w_probe = w_probe + w_step;
            if (w_probe >= N_W) begin
                w_probe = w_probe - N_W;
            end else begin
                w_probe = w_probe;
            end
            if (!w_found && !r_matched[w_probe[IDX_W-1:0]]) begin
                w_target = w_probe[IDX_W-1:0];
                w_found  = 1'b1;
            end else begin
                w_found  = w_found;
            end
        end
    end

    assign w_cur_hidden = !r_revealed[r_cursor] && !r_matched[r_cursor];
    assign w_colors_eq  = (colors[r_first*COLOR_W +: COLOR_W] ==
                           colors[r_second*COLOR_W +: COLOR_W]);
    assign w_cnt_inc    = (r_match_cnt < HALF_W) ? (r_match_cnt + IDX_W'(1)) : r_match_cnt;

    // Game FSM state register.
    always_ff @(posedge clk25MHz or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Game FSM next-state and datapath strobes.
    always_comb begin
        w_state_nxt   = r_state;
        w_move_ok     = 1'b0;
        w_take_first  = 1'b0;
        w_take_second = 1'b0;
        w_do_match    = 1'b0;
        w_do_mismatch = 1'b0;
        w_do_hide     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_move_ok = 1'b1;
                if (w_sel_evt && w_cur_hidden) begin
                    w_take_first = 1'b1;
                    w_state_nxt  = S_ONE;
                end else begin
                    w_state_nxt  = S_IDLE;
                end
            end
            S_ONE: begin
                w_move_ok = 1'b1;
                if (w_sel_evt && w_cur_hidden && (r_cursor != r_first)) begin
                    w_take_second = 1'b1;
                    w_state_nxt   = S_CHECK;
                end else begin
                    w_state_nxt   = S_ONE;
                end
            end
            S_CHECK: begin
                if (w_colors_eq) begin
                    w_do_match  = 1'b1;
                    w_state_nxt = (w_cnt_inc == HALF_W) ? S_DONE : S_IDLE;
                end else begin
                    w_do_mismatch = 1'b1;
                    w_state_nxt   = S_SHOW;
                end
            end
            S_SHOW: begin
                w_move_ok = 1'b1;
                if (r_timer == '0) begin
                    w_do_hide   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_SHOW;
                end
            end
            S_DONE:  w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Cursor, square flags, match counter, hold timer and registered flags.
    always_ff @(posedge clk25MHz or negedge rst) begin
        if (!rst) begin
            r_cursor    <= '0;
            r_first     <= '0;
            r_second    <= '0;
            r_match_cnt <= '0;
            r_revealed  <= '0;
            r_matched   <= '0;
            r_timer     <= '0;
            r_mismatch  <= 1'b0;
            r_game_done <= 1'b0;
        end else begin
            r_mismatch  <= w_do_mismatch;
            r_game_done <= (w_state_nxt == S_DONE);
            // Selects use the pre-move cursor; the move lands on the same edge.
            if (w_move_evt && w_move_ok) begin
                r_cursor <= w_target;
            end else begin
                r_cursor <= r_cursor;
            end
            if (w_take_first) begin
                r_revealed[r_cursor] <= 1'b1;
                r_first              <= r_cursor;
            end else if (w_take_second) begin
                r_revealed[r_cursor] <= 1'b1;
                r_second             <= r_cursor;
            end else if (w_do_match) begin
                r_matched[r_first]   <= 1'b1;
                r_matched[r_second]  <= 1'b1;
                r_revealed[r_first]  <= 1'b0;
                r_revealed[r_second] <= 1'b0;
                r_match_cnt          <= w_cnt_inc;
            end else if (w_do_hide) begin
                r_revealed[r_first]  <= 1'b0;
                r_revealed[r_second] <= 1'b0;
            end else begin
                r_revealed <= r_revealed;
            end
            if (w_do_mismatch) begin
                r_timer <= SHOW_LOAD;
            end else if ((r_state == S_SHOW) && (r_timer != '0)) begin
                r_timer <= r_timer - CNT_W'(1);
            end else begin
                r_timer <= r_timer;
            end
        end
    end

    // Per-square display code: matched > revealed > cursor > hidden.
    always_comb begin
        sq_state = '0;
        for (int i = 0; i < N; i++) begin
            if (r_matched[i]) begin
                sq_state[2*i +: 2] = 2'b11;
            end else if (r_revealed[i]) begin
                sq_state[2*i +: 2] = 2'b10;
            end else if (r_cursor == IDX_W'(i)) begin
                sq_state[2*i +: 2] = 2'b01;
            end else begin
                sq_state[2*i +: 2] = 2'b00;
            end
        end
    end

    assign cursor      = r_cursor;
    assign match_count = r_match_cnt;
    assign mismatch    = r_mismatch;
    assign game_done   = r_game_done;

endmodule

// File: tb/tb_match_grid_ctrl.sv
// -----------------------------------------------------------------------------
// tb_match_grid_ctrl
// Directed testbench for match_grid_ctrl on a 4x2 grid with a 10-cycle show
// time. Expected values are worked out by hand from the game rules.
// -----------------------------------------------------------------------------
module tb_match_grid_ctrl;

    localparam int COLS = 4, ROWS = 2, N = 8, IDX_W = 3, COLOR_W = 3;
    localparam int SHOW_CYCLES = 10, CNT_W = 4;
    localparam logic [3:0] UP = 4'b1000, DN = 4'b0100, LT = 4'b0010, RT = 4'b0001;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [3:0]             switches;
    logic                   select_button;
    logic [N*COLOR_W-1:0]   colors;
    logic [2*N-1:0]         sq_state;
    logic [IDX_W-1:0]       cursor, match_count;
    logic                   mismatch, game_done;

    int n_cmp = 0;
    int n_mis = 0;
    int mm_total = 0;
    int rev_cnt = 0;
    bit mm_track = 1'b0;
    int mm0;

    match_grid_ctrl #(
        .COLS(COLS), .ROWS(ROWS), .IDX_W(IDX_W), .COLOR_W(COLOR_W),
        .SHOW_CYCLES(SHOW_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk25MHz(clk), .rst(rst), .switches(switches),
        .select_button(select_button), .colors(colors), .sq_state(sq_state),
        .cursor(cursor), .match_count(match_count), .mismatch(mismatch),
        .game_done(game_done)
    );

    always #20 clk = ~clk;

    // Count mismatch pulses and how long square 2 stays revealed after one.
    always @(negedge clk) begin
        if (mismatch) begin
            mm_total++;
            rev_cnt  = 0;
            mm_track = 1'b1;
        end
        if (mm_track && (sq_state[5:4] == 2'b10)) begin
            rev_cnt++;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic move(input logic [3:0] dir);
        switches = dir;
        @(negedge clk);
        switches = 4'b0000;
        repeat (2) @(negedge clk);
    endtask

    task automatic press();
        select_button = 1'b1;
        @(negedge clk);
        select_button = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; switches = 4'b0000; select_button = 1'b0;
        colors = {3'd5, 3'd5, 3'd3, 3'd4, 3'd2, 3'd4, 3'd2, 3'd3};
        repeat (3) @(negedge clk);
        check_val("rst_cursor", 32'(cursor), 32'd0);
        check_val("rst_sq", 32'(sq_state), 32'h0001);
        check_val("rst_count", 32'(match_count), 32'd0);
        check_val("rst_done", 32'(game_done), 32'd0);
        check_val("rst_mismatch", 32'(mismatch), 32'd0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check_val("idle_cursor", 32'(cursor), 32'd0);
        check_val("idle_sq", 32'(sq_state), 32'h0001);

        // Latency: the move lands on the third rising edge.
        switches = RT;
        @(posedge clk); #1;
        check_val("lat_e1", 32'(cursor), 32'd0);
        switches = 4'b0000;
        @(posedge clk); #1;
        check_val("lat_e2", 32'(cursor), 32'd0);
        @(posedge clk); #1;
        check_val("lat_e3", 32'(cursor), 32'd1);
        repeat (3) @(negedge clk);

        for (int i = 0; i < 7; i++) move(RT);
        check_val("wrap_right", 32'(cursor), 32'd0);
        move(RT); move(RT);
        move(DN);
        check_val("down_2_6", 32'(cursor), 32'd6);
        move(UP); move(LT);
        check_val("left_2_1", 32'(cursor), 32'd1);
        move(UP);
        check_val("up_1_5", 32'(cursor), 32'd5);
        move(4'b1100);
        check_val("no_onehot", 32'(cursor), 32'd5);
        switches = RT;
        repeat (6) @(negedge clk);
        switches = 4'b0000;
        repeat (3) @(negedge clk);
        check_val("hold_once", 32'(cursor), 32'd6);
        move(LT);

        // Matching pair 0/5.
        move(UP); move(LT);
        press();
        check_val("first_rev", 32'(sq_state), 32'h0002);
        mm0 = mm_total;
        move(RT); move(DN);
        press();
        @(negedge clk);
        check_val("match_sq", 32'(sq_state), 32'h0C03);
        check_val("match_count1", 32'(match_count), 32'd1);
        check_val("match_no_mm", 32'(mm_total - mm0), 32'd0);
        check_val("match_not_done", 32'(game_done), 32'd0);

        // Mismatch 1/2, with a move and a select during the show time.
        move(UP);
        press();
        move(RT);
        mm0 = mm_total;
        press();
        move(RT);
        press();
        check_val("show_sel_ignored", 32'(sq_state), 32'h0C6B);
        repeat (8) @(negedge clk);
        check_val("mm_pulses", 32'(mm_total - mm0), 32'd1);
        check_val("show_len", 32'(rev_cnt), 32'd10);
        check_val("hidden_again", 32'(sq_state), 32'h0C43);
        check_val("show_cursor", 32'(cursor), 32'd3);

        // Finish the game: pairs 3/1, 2/4, 6/7.
        press();
        move(LT); move(LT);
        press();
        @(negedge clk);
        check_val("match_count2", 32'(match_count), 32'd2);
        move(RT);
        press();
        move(RT);
        check_val("skip_to_4", 32'(cursor), 32'd4);
        press();
        @(negedge clk);
        check_val("match_count3", 32'(match_count), 32'd3);
        move(RT);
        check_val("skip_to_6", 32'(cursor), 32'd6);
        press();
        move(RT);
        press();
        @(negedge clk);
        check_val("done_flag", 32'(game_done), 32'd1);
        check_val("done_count", 32'(match_count), 32'd4);
        check_val("done_sq", 32'(sq_state), 32'hFFFF);
        move(LT);
        check_val("done_move_ignored", 32'(cursor), 32'd7);
        press();
        check_val("done_count_hold", 32'(match_count), 32'd4);
        check_val("game_mm_total", 32'(mm_total - mm0), 32'd1);

        // Asynchronous reset out of DONE.
        rst = 1'b0;
        #1;
        check_val("arst_done", 32'(game_done), 32'd0);
        check_val("arst_count", 32'(match_count), 32'd0);
        check_val("arst_sq", 32'(sq_state), 32'h0001);
        colors = {3'd1, 3'd2, 3'd2, 3'd7, 3'd7, 3'd6, 3'd6, 3'd1};
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Mismatch 1/3, then reset in the middle of the show time.
        move(RT);
        press();
        move(RT); move(RT);
        press();
        repeat (3) @(negedge clk);
        check_val("show_before_rst", 32'(sq_state), 32'h0088);
        rst = 1'b0;
        #1;
        check_val("mid_show_cursor", 32'(cursor), 32'd0);
        check_val("mid_show_sq", 32'(sq_state), 32'h0001);
        check_val("mid_show_mm", 32'(mismatch), 32'd0);
        check_val("mid_show_count", 32'(match_count), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Skip tests in the second game.
        move(RT);
        press();
        move(RT);
        press();
        @(negedge clk);
        check_val("g2_count1", 32'(match_count), 32'd1);
        move(LT);
        check_val("skip_left_0", 32'(cursor), 32'd0);
        move(RT);
        check_val("skip_right_3", 32'(cursor), 32'd3);
        press();
        move(RT);
        press();
        @(negedge clk);
        move(RT);
        press();
        move(RT);
        press();
        @(negedge clk);
        check_val("g2_count3", 32'(match_count), 32'd3);
        move(RT); move(RT);
        check_val("wrap_to_0", 32'(cursor), 32'd0);
        move(DN);
        check_val("down_no_target", 32'(cursor), 32'd0);
        move(RT);
        check_val("skip_right_7", 32'(cursor), 32'd7);
        press();
        move(LT);
        check_val("skip_left_7_0", 32'(cursor), 32'd0);
        press();
        @(negedge clk);
        check_val("g2_done", 32'(game_done), 32'd1);
        check_val("g2_count4", 32'(match_count), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
